pad_input_filter: RTL and testbench

// Conditions the raw input value returned by a bidirectional pad cell before core logic uses it.

---
 rtl/pad_input_filter_if.sv | 12 +
 rtl/pad_input_filter.sv | 66 ++++++
 tb/tb_pad_input_filter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pad_input_filter_if.sv
// pad_input_filter_if: pad value, filter controls and filtered outputs of pad_input_filter
interface pad_input_filter_if #(parameter int CNT_W = 8);
  logic             pad_out_i;
  logic             en_i;
  logic [CNT_W-1:0] debounce_cycles_i;
  logic             level_o;
  logic             rise_o;
  logic             fall_o;
  logic [15:0]      glitch_cnt_o;
  modport master (output pad_out_i, en_i, debounce_cycles_i, input level_o, rise_o, fall_o, glitch_cnt_o);
  modport slave  (input pad_out_i, en_i, debounce_cycles_i, output level_o, rise_o, fall_o, glitch_cnt_o);
endinterface

// File: rtl/pad_input_filter.sv
// pad_input_filter: synchronizer, debounce filter and edge pulses for a raw pad input.
// Define PAD_FILTER_STATS_EN to enable the saturating rejected-glitch counter.
module pad_input_filter #(
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_W       = 8,
  parameter logic RESET_VAL   = 1'b0
) (
  input logic              clk_i,
  input logic              rst_i,
  pad_input_filter_if.slave bus
);
  typedef enum logic {STABLE, CAND} state_t;
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d, n;
  logic                   level_q, rise_q, fall_q;
  logic                   sync, diff, commit, rise_d, fall_d;
  assign sync = sync_q[SYNC_STAGES-1];
  assign diff = sync != level_q;
  assign n    = (bus.debounce_cycles_i == '0) ? CNT_W'(1) : bus.debounce_cycles_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= {SYNC_STAGES{RESET_VAL}};
      level_q <= RESET_VAL;
      state_q <= STABLE;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.pad_out_i};
      level_q <= commit ? sync : level_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end
  // Disabling or agreeing with level_o always returns to STABLE with a cleared count.
  always_comb begin
    state_d = (bus.en_i && diff && !commit) ? CAND : STABLE;
    cnt_d   = (!bus.en_i || !diff || commit) ? '0 :
              (state_q == STABLE) ? CNT_W'(1) :
              (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  end
  always_comb begin
    commit = bus.en_i && diff &&
             ((state_q == STABLE) ? (n == CNT_W'(1)) : (({1'b0, cnt_q} + (CNT_W+1)'(1)) >= {1'b0, n}));
    rise_d = commit && sync;
    fall_d = commit && !sync;
  end
  assign bus.level_o = level_q;
  assign bus.rise_o  = rise_q;
  assign bus.fall_o  = fall_q;
`ifdef PAD_FILTER_STATS_EN
  logic        reject;
  logic [15:0] glitch_q;
  assign reject = bus.en_i && !diff && (state_q == CAND);
  always_ff @(posedge clk_i) begin
    if (rst_i) glitch_q <= '0;
    else if (reject && !(&glitch_q)) glitch_q <= glitch_q + 16'd1;
  end
  assign bus.glitch_cnt_o = glitch_q;
`else
  assign bus.glitch_cnt_o = 16'h0;
`endif
endmodule

// File: tb/tb_pad_input_filter.sv
// tb_pad_input_filter: directed checks of pad_input_filter (SYNC_STAGES=2, CNT_W=8, RESET_VAL=0)
module tb_pad_input_filter;
`ifdef PAD_FILTER_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  pad_input_filter_if #(.CNT_W(8)) intf ();
  pad_input_filter #(.SYNC_STAGES(2), .CNT_W(8), .RESET_VAL(1'b0)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (intf.slave)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int k = 1);
    repeat (k) begin
      @(posedge clk_i);
      #1;
    end
  endtask
  task automatic chk_out(input string tag, input logic lvl, input logic r, input logic f);
    chk({tag, ".level"}, {31'd0, intf.level_o}, {31'd0, lvl});
    chk({tag, ".rise"},  {31'd0, intf.rise_o},  {31'd0, r});
    chk({tag, ".fall"},  {31'd0, intf.fall_o},  {31'd0, f});
  endtask
  initial begin
    intf.pad_out_i = 1'b0;
    intf.en_i = 1'b1;
    intf.debounce_cycles_i = 8'd4;
    rst_i = 1'b1;
    step(2);
    rst_i = 1'b0;
    chk_out("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.glitch", {16'd0, intf.glitch_cnt_o}, 32'd0);
    // 1) clean rise with N=4: level_o changes after 6 edges
    intf.pad_out_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk_out($sformatf("t1.c%0d", i), 1'b0, 1'b0, 1'b0);
    end
    step();
    chk_out("t1.c6", 1'b1, 1'b1, 1'b0);
    step();
    chk_out("t1.c7", 1'b1, 1'b0, 1'b0);
    // 3) N=0 and N=1 behave alike: fall after 3 edges
    intf.debounce_cycles_i = 8'd0;
    intf.pad_out_i = 1'b0;
    step(2);
    chk_out("t3a.c2", 1'b1, 1'b0, 1'b0);
    step();
    chk_out("t3a.c3", 1'b0, 1'b0, 1'b1);
    step();
    chk_out("t3a.c4", 1'b0, 1'b0, 1'b0);
    intf.debounce_cycles_i = 8'd1;
    intf.pad_out_i = 1'b1;
    step(5);
    chk_out("t3b.rehigh", 1'b1, 1'b0, 1'b0);
    intf.pad_out_i = 1'b0;
    step(2);
    chk_out("t3b.c2", 1'b1, 1'b0, 1'b0);
    step();
    chk_out("t3b.c3", 1'b0, 1'b0, 1'b1);
    step();
    chk_out("t3b.c4", 1'b0, 1'b0, 1'b0);
    // 2) 3-cycle glitch with N=4 is rejected
    intf.debounce_cycles_i = 8'd4;
    intf.pad_out_i = 1'b1;
    step(3);
    intf.pad_out_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_out($sformatf("t2.c%0d", i), 1'b0, 1'b0, 1'b0);
    end
    chk("t2.glitch", {16'd0, intf.glitch_cnt_o}, STATS);
    // 4) disabled: pad toggles, level_o frozen, no pulses
    intf.en_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      intf.pad_out_i = ~intf.pad_out_i;
      step();
      chk_out($sformatf("t4.tog%0d", i), 1'b0, 1'b0, 1'b0);
    end
    intf.pad_out_i = 1'b1;
    step(3);
    chk_out("t4.held", 1'b0, 1'b0, 1'b0);
    intf.en_i = 1'b1;
    step(3);
    chk_out("t4.c3", 1'b0, 1'b0, 1'b0);
    step();
    chk_out("t4.c4", 1'b1, 1'b1, 1'b0);
    chk("t4.glitch", {16'd0, intf.glitch_cnt_o}, STATS);
    // 5) reset while CANDIDATE with cnt=3 discards the change
    intf.pad_out_i = 1'b0;
    step(5);
    chk_out("t5.pre", 1'b1, 1'b0, 1'b0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk_out("t5.rst", 1'b0, 1'b0, 1'b0);
    chk("t5.glitch", {16'd0, intf.glitch_cnt_o}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk_out($sformatf("t5.post%0d", i), 1'b0, 1'b0, 1'b0);
    end
    // 6) N=200 lowered to 5 at cnt=10 commits on the next differing sample
    intf.pad_out_i = 1'b1;
    step(8);
    chk_out("t6.high", 1'b1, 1'b0, 1'b0);
    intf.debounce_cycles_i = 8'd200;
    intf.pad_out_i = 1'b0;
    step(12);
    chk_out("t6.c12", 1'b1, 1'b0, 1'b0);
    intf.debounce_cycles_i = 8'd5;
    step();
    chk_out("t6.c13", 1'b0, 1'b0, 1'b1);
    step();
    chk_out("t6.c14", 1'b0, 1'b0, 1'b0);
    // 100 single-cycle glitches counted from a fresh reset
    rst_i = 1'b1;
    intf.debounce_cycles_i = 8'd4;
    step();
    rst_i = 1'b0;
    for (int i = 0; i < 100; i++) begin
      intf.pad_out_i = 1'b1;
      step();
      intf.pad_out_i = 1'b0;
      step(3);
      if (intf.rise_o || intf.fall_o || intf.level_o) chk($sformatf("t6.g%0d", i), {29'd0, intf.level_o, intf.rise_o, intf.fall_o}, 32'd0);
    end
    step(4);
    chk_out("t6.gend", 1'b0, 1'b0, 1'b0);
    chk("t6.glitch100", {16'd0, intf.glitch_cnt_o}, STATS * 100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
